// File: rtl/channel_reorder_pingpong.sv
// Double-buffered channel reorder: strips packet headers and transposes SAMPLES_PER_WORD
// packets per bank so each output word carries consecutive time samples of one channel.
module channel_reorder_pingpong #(
  parameter int                  SAMPLE_W         = 16,
  parameter int                  NUM_CH           = 128,
  parameter int                  SAMPLES_PER_WORD = 16,
  parameter logic [SAMPLE_W-1:0] HEADER           = 16'hDEAD,
  parameter int                  DROP_ON_FULL     = 0
) (
  input  logic                                 inclk,
  input  logic                                 rst_n,
  input  logic [SAMPLE_W-1:0]                  in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [SAMPLE_W*SAMPLES_PER_WORD-1:0] out_data,
  output logic [$clog2(NUM_CH)-1:0]            out_ch,
  output logic                                 out_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [1:0]                           bank_full,
  output logic [15:0]                          drop_cnt,
  output logic [15:0]                          resync_cnt
);

  localparam int CH_W   = $clog2(NUM_CH);
  localparam int PKT_W  = $clog2(SAMPLES_PER_WORD);
  localparam int WORD_W = SAMPLE_W * SAMPLES_PER_WORD;
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(SAMPLES_PER_WORD - 1);

  typedef enum logic [1:0] {HUNT, WRITE, DROP} wr_state_t;
  typedef enum logic       {RD_IDLE, RD_RUN}   rd_state_t;

  wr_state_t        wr_state, wr_next;
  rd_state_t        rd_state, rd_next;
  logic             wr_bank, rd_bank;
  logic [PKT_W-1:0] pkt_idx;
  logic [CH_W-1:0]  ch, rd_addr;
  logic             rd_done;
  logic             accept, hdr_hit, resync_inc, wr_en, drop_en;
  logic             pkt_end, fill_done, drop_done;
  logic             rd_issue, out_hs, rd_finish;
  logic [1:0]       set_mask, clr_mask;

  // Each bank address holds one channel across all lanes, so a single read yields an output word
  logic [WORD_W-1:0] mem [2][NUM_CH];

  always_ff @(posedge inclk) begin
    if (!rst_n) wr_state <= HUNT;
    else        wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      HUNT:    if (hdr_hit)   wr_next = bank_full[wr_bank] ? DROP : WRITE;
      WRITE:   if (pkt_end)   wr_next = HUNT;
      DROP:    if (drop_done) wr_next = HUNT;
      default:                wr_next = HUNT;
    endcase
  end

  // In backpressure mode the header is held on the input until the target bank drains
  always_comb begin
    in_ready   = !((DROP_ON_FULL == 0) && (wr_state == HUNT) && bank_full[wr_bank]);
    accept     = in_valid && in_ready;
    hdr_hit    = accept && (wr_state == HUNT) && (in_data == HEADER);
    resync_inc = accept && (wr_state == HUNT) && (in_data != HEADER);
    wr_en      = accept && (wr_state == WRITE);
    drop_en    = accept && (wr_state == DROP);
    pkt_end    = wr_en && (ch == CH_LAST);
    fill_done  = pkt_end && (pkt_idx == PKT_LAST);
    drop_done  = drop_en && (ch == CH_LAST);
    set_mask   = fill_done ? {wr_bank, ~wr_bank} : 2'b00;
  end

  always_ff @(posedge inclk) begin
    if (!rst_n) begin
      ch         <= '0;
      pkt_idx    <= '0;
      wr_bank    <= 1'b0;
      drop_cnt   <= '0;
      resync_cnt <= '0;
    end else begin
      if (hdr_hit)
        ch <= '0;
      else if (wr_en || drop_en)
        ch <= (ch == CH_LAST) ? '0 : ch + 1'b1;
      if (pkt_end) begin
        if (pkt_idx == PKT_LAST) begin
          pkt_idx <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          pkt_idx <= pkt_idx + 1'b1;
        end
      end
      if (drop_done && (drop_cnt != 16'hFFFF))
        drop_cnt <= drop_cnt + 16'd1;
      if (resync_inc && (resync_cnt != 16'hFFFF))
        resync_cnt <= resync_cnt + 16'd1;
    end
  end

  always_ff @(posedge inclk) begin
    if (wr_en)
      mem[wr_bank][ch][int'(pkt_idx)*SAMPLE_W +: SAMPLE_W] <= in_data;
  end

  // Fill and drain always target different banks, so set and clear can both apply
  always_ff @(posedge inclk) begin
    if (!rst_n) bank_full <= 2'b00;
    else        bank_full <= (bank_full | set_mask) & ~clr_mask;
  end

  always_ff @(posedge inclk) begin
    if (!rst_n) rd_state <= RD_IDLE;
    else        rd_state <= rd_next;
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (bank_full[rd_bank]) rd_next = RD_RUN;
      RD_RUN:  if (rd_finish)          rd_next = RD_IDLE;
      default:                         rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    out_hs    = out_valid && out_ready;
    rd_issue  = (rd_state == RD_RUN) && !rd_done && (!out_valid || out_ready);
    rd_finish = (rd_state == RD_RUN) && out_hs && out_last;
    clr_mask  = rd_finish ? {rd_bank, ~rd_bank} : 2'b00;
  end

  // The memory read lands directly in the output register, which holds while stalled
  always_ff @(posedge inclk) begin
    if (!rst_n) begin
      rd_bank   <= 1'b0;
      rd_addr   <= '0;
      rd_done   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
    end else begin
      if (rd_finish)
        rd_bank <= ~rd_bank;
      if (rd_state == RD_IDLE) begin
        rd_addr <= '0;
        rd_done <= 1'b0;
      end else if (rd_issue) begin
        rd_addr <= rd_addr + 1'b1;
        rd_done <= (rd_addr == CH_LAST);
      end
      if (rd_issue) begin
        out_data  <= mem[rd_bank][rd_addr];
        out_ch    <= rd_addr;
        out_last  <= (rd_addr == CH_LAST);
        out_valid <= 1'b1;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
